gpio_port: RTL and testbench
============================

# gpio_port

Memory-mapped 8-bit MSP430-style digital I/O port: PxIN/PxOUT/PxDIR/PxREN/PxSEL0/PxIES/PxIE/PxIFG/PxIV registers on the peripheral bus. It is the logic-side controller for the eight pad IOBUFs: it drives each IOBUF's I and T inputs and samples each IOBUF's O output. It synchronizes pad inputs, detects edges, and raises a port interrupt to the CPU interrupt logic.

## Interface
- BASE, 16'h0200: byte address of PxIN; all other registers are offsets from it.
- PORT_IV, 1: when 0, PxIV reads as 0 and never clears flags.
- MCLK  in  1  system clock; all state changes on the rising edge.
- RSTn  in  1  reset, asynchronous and active-low.
- MAB  in  16  memory address bus.
- MDBin  in  16  write data.
- MDBout  out  16  read data; 0 when not addressed.
- MW  in  1  write strobe, one cycle.
- MR  in  1  read strobe, one cycle.
- BW  in  1  byte access.
- PAD_O  in  8  from IOBUF O, asynchronous to MCLK.
- PAD_I  out  8  to IOBUF I.
- PAD_T  out  8  to IOBUF T; 1 means the pad is tri-stated.
- PER_OUT  in  8  peripheral-function output data.
- PER_OE  in  8  peripheral-function output enable.
- PER_IN  out  8  synchronized pad value for peripherals; equals PxIN.
- PULL_EN  out  8  PxREN to pad pull models.
- PULL_UP  out  8  PxOUT & PxREN.
- INT  out  1  |(PxIFG & PxIE).

## Operation
- Register offsets: IN 0x00 (read-only), OUT 0x02, DIR 0x04, REN 0x06, SEL0 0x0A, IV 0x0E (read-only), IES 0x18, IE 0x1A, IFG 0x1C.
- Reads:
  - A read at an even address returns {8'h00, reg}.
  - An odd address, or a BW read of an odd address, returns 0.
  - MDBout is combinational from MAB.
- Writes:
  - A write at an even address with MW loads MDBin[7:0].
  - A BW write to an odd address is ignored.
  - Writes to IN and IV are ignored.
- Pad drive, per bit n:
  - SEL0[n]=0: PAD_I=OUT[n], PAD_T=~DIR[n].
  - SEL0[n]=1: PAD_I=PER_OUT[n], PAD_T=~PER_OE[n].
- Input path: a per-bit chain of three flops s1→s2→s3 on PAD_O. PxIN = s2.
- Edge detection:
  - Rising edge = ~s3&s2 when IES[n]=0.
  - Falling edge = s3&~s2 when IES[n]=1.
  - A detected edge sets IFG[n] regardless of IE[n] or SEL0[n].
- Writes to IES never set IFG.
- PxIV:
  - Value is 2·(n+1) for the lowest n with IFG[n]&IE[n]; 0 if there is none.
  - A read of IV (MR and MAB==BASE+0x0E) clears that IFG bit on the same edge.
- Simultaneous events on one IFG bit in one edge: a hardware set wins over a software write of 0 and over an IV-read clear.
- Other bits written in the same cycle take the written value.
- IV snapshot is taken before the edge. A higher-priority flag set on the same edge is reported on the next read.
- Reset (RSTn=0):
  - OUT, DIR, REN, SEL0, IES, IE, IFG = 0.
  - s1, s2, s3 = 0.
  - PAD_T = 8'hFF, PAD_I = 0, INT = 0, PULL_EN = PULL_UP = 0.
- Reset mid-operation: the first s2≠s3 difference after RSTn rises is treated as a real edge.

## Timing
- Register write: value visible on PAD_I/PAD_T/PULL_* and readback immediately after the write edge (0 cycles of added latency).
- PAD_O change: appears in PxIN after the 2nd MCLK edge.
- IFG set: on the 3rd edge after the PAD_O change.
- INT: rises combinationally with IFG when IE=1.
- Pulses on PAD_O shorter than one MCLK period may be missed.
- A pulse that is captured by s1 and held ≥1 cycle generates exactly one flag per qualifying edge.
- No wait states; every access completes in one cycle.

## Structure
- Register offsets and IV encodings go in the shared NEW/PARAMS.v include; nothing else is shared.
- One sub-module, gpio_sync: 8-bit three-flop synchronizer plus IES-selected edge detect. Its outputs are sync (s2) and edge[7:0].
- gpio_port holds the register file, bus decode, pad mux and IV logic.

## Test plan
- Reset:
  - Assert RSTn=0 mid-traffic → PAD_T=8'hFF, INT=0, and every register reads 0x0000 within the same cycle.
  - After release, write DIR=0x0F, OUT=0x05 → PAD_T=0xF0, PAD_I=0x05.
- Input sync: PAD_O 0x00→0x81 at cycle 0, IES=0, IE=0x01 →
  - IN reads 0x81 after edge 2.
  - IFG=0x81 after edge 3.
  - INT=1, IV reads 0x0002.
  - A second IV read returns 0x0000; IFG then reads 0x80.
- Falling-edge select: IES=0xFF, PAD_O 0xFF→0xFE → IFG=0x01. Then writing IES=0x00 leaves IFG unchanged.
- Set-vs-clear collision: a rising edge on bit 3 coincides with a write IFG=0x00 → IFG=0x08 afterwards. The same holds for an IV read that clears bit 3.
- Peripheral mux: SEL0=0x10, PER_OE=0x10, PER_OUT=0x10, DIR=0 → PAD_T[4]=0, PAD_I[4]=1, while the other bits follow OUT/DIR.
- Bus decode:
  - A BW write of 0xAB to BASE+0x03 is ignored.
  - A word write of 0x12FF to BASE+0x02 → OUT=0xFF, and readback is 0x00FF.
  - A read of an unmapped offset 0x08 returns 0.

Source files
------------

// File: rtl/gpio_port_pkg.sv
// Shared register offsets and interrupt-vector helpers for the 8-bit GPIO port.
package gpio_port_pkg;

  localparam int unsigned PortWidth = 8;

  localparam logic [4:0] OffIn   = 5'h00;
  localparam logic [4:0] OffOut  = 5'h02;
  localparam logic [4:0] OffDir  = 5'h04;
  localparam logic [4:0] OffRen  = 5'h06;
  localparam logic [4:0] OffSel0 = 5'h0A;
  localparam logic [4:0] OffIv   = 5'h0E;
  localparam logic [4:0] OffIes  = 5'h18;
  localparam logic [4:0] OffIe   = 5'h1A;
  localparam logic [4:0] OffIfg  = 5'h1C;

  // Lowest pending bit n wins and encodes as 2*(n+1); none pending gives 0.
  function automatic logic [15:0] iv_encode(input logic [PortWidth-1:0] pend);
    logic [15:0] v;
    v = 16'h0000;
    for (int i = PortWidth - 1; i >= 0; i--) begin
      if (pend[i]) v = 16'((i + 1) * 2);
    end
    return v;
  endfunction

  function automatic logic [PortWidth-1:0] lowest_onehot(input logic [PortWidth-1:0] pend);
    return pend & (~pend + 8'd1);
  endfunction

endpackage

// File: rtl/gpio_sync.sv
// Three-flop pad synchronizer with per-bit rising/falling edge detect selected by IES.
module gpio_sync
  import gpio_port_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [PortWidth-1:0] pad_i,
  input  logic [PortWidth-1:0] ies_i,
  output logic [PortWidth-1:0] sync_o,
  output logic [PortWidth-1:0] edge_o
);

  logic [PortWidth-1:0] s1_q, s2_q, s3_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else begin
      s1_q <= pad_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign sync_o = s2_q;
  // s3 holds the previous synchronized value, so each transition is flagged exactly once.
  assign edge_o = (ies_i & s3_q & ~s2_q) | (~ies_i & ~s3_q & s2_q);

endmodule

// File: rtl/gpio_port.sv
// MSP430-style 8-bit digital I/O port: register file, bus decode, pad mux and PxIV logic.
module gpio_port
  import gpio_port_pkg::*;
#(
  parameter logic [15:0] BASE    = 16'h0200,
  parameter bit          PORT_IV = 1'b1
) (
  input  logic        MCLK,
  input  logic        RSTn,
  input  logic [15:0] MAB,
  input  logic [15:0] MDBin,
  output logic [15:0] MDBout,
  input  logic        MW,
  input  logic        MR,
  input  logic        BW,
  input  logic [7:0]  PAD_O,
  output logic [7:0]  PAD_I,
  output logic [7:0]  PAD_T,
  input  logic [7:0]  PER_OUT,
  input  logic [7:0]  PER_OE,
  output logic [7:0]  PER_IN,
  output logic [7:0]  PULL_EN,
  output logic [7:0]  PULL_UP,
  output logic        INT
);

  logic [7:0] out_q, out_d, dir_q, dir_d, ren_q, ren_d, sel0_q, sel0_d;
  logic [7:0] ies_q, ies_d, ie_q, ie_d, ifg_q, ifg_d;
  logic [7:0] pin_sync, pin_edge;

  logic [15:0] addr_off;
  logic [4:0]  reg_off;
  logic        hit, wr, iv_rd;
  logic [7:0]  iv_pend, iv_clr, rdata;
  logic [15:0] iv_val;
  logic        unused_bits;

  // Odd addresses never decode, which also drops byte accesses to the high byte.
  assign addr_off = MAB - BASE;
  assign reg_off  = addr_off[4:0];
  assign hit      = (addr_off[15:5] == 11'd0) && !addr_off[0];
  assign wr       = MW && hit;

  assign unused_bits = ^{MDBin[15:8], BW};

  gpio_sync u_sync (
    .clk_i  (MCLK),
    .rst_ni (RSTn),
    .pad_i  (PAD_O),
    .ies_i  (ies_q),
    .sync_o (pin_sync),
    .edge_o (pin_edge)
  );

  assign iv_pend = ifg_q & ie_q;
  assign iv_val  = PORT_IV ? iv_encode(iv_pend) : 16'h0000;
  assign iv_rd   = PORT_IV && MR && hit && (reg_off == OffIv);
  assign iv_clr  = iv_rd ? lowest_onehot(iv_pend) : 8'h00;

  always_comb begin
    out_d  = out_q;
    dir_d  = dir_q;
    ren_d  = ren_q;
    sel0_d = sel0_q;
    ies_d  = ies_q;
    ie_d   = ie_q;
    ifg_d  = ifg_q;
    if (wr) begin
      case (reg_off)
        OffOut:  out_d  = MDBin[7:0];
        OffDir:  dir_d  = MDBin[7:0];
        OffRen:  ren_d  = MDBin[7:0];
        OffSel0: sel0_d = MDBin[7:0];
        OffIes:  ies_d  = MDBin[7:0];
        OffIe:   ie_d   = MDBin[7:0];
        OffIfg:  ifg_d  = MDBin[7:0];
        default: ;
      endcase
    end
    // Hardware edges override both software clears and the IV-read clear.
    ifg_d = (ifg_d & ~iv_clr) | pin_edge;
  end

  always_ff @(posedge MCLK or negedge RSTn) begin
    if (!RSTn) begin
      out_q  <= '0;
      dir_q  <= '0;
      ren_q  <= '0;
      sel0_q <= '0;
      ies_q  <= '0;
      ie_q   <= '0;
      ifg_q  <= '0;
    end else begin
      out_q  <= out_d;
      dir_q  <= dir_d;
      ren_q  <= ren_d;
      sel0_q <= sel0_d;
      ies_q  <= ies_d;
      ie_q   <= ie_d;
      ifg_q  <= ifg_d;
    end
  end

  always_comb begin
    rdata = 8'h00;
    case (reg_off)
      OffIn:   rdata = pin_sync;
      OffOut:  rdata = out_q;
      OffDir:  rdata = dir_q;
      OffRen:  rdata = ren_q;
      OffSel0: rdata = sel0_q;
      OffIv:   rdata = iv_val[7:0];
      OffIes:  rdata = ies_q;
      OffIe:   rdata = ie_q;
      OffIfg:  rdata = ifg_q;
      default: rdata = 8'h00;
    endcase
  end

  assign MDBout  = hit ? {8'h00, rdata} : 16'h0000;

  assign PAD_I   = (sel0_q & PER_OUT) | (~sel0_q & out_q);
  assign PAD_T   = ~((sel0_q & PER_OE) | (~sel0_q & dir_q));
  assign PER_IN  = pin_sync;
  assign PULL_EN = ren_q;
  assign PULL_UP = out_q & ren_q;
  assign INT     = |(ifg_q & ie_q);

endmodule

// File: tb/tb_gpio_port.sv
// Directed self-checking bench for gpio_port with hand-computed expectations.
module tb_gpio_port;

  localparam logic [15:0] Base = 16'h0200;

  logic        mclk = 1'b0;
  logic        rstn;
  logic [15:0] mab, mdb_in, mdb_out;
  logic        mw, mr, bw;
  logic [7:0]  pad_o, pad_i, pad_t, per_out, per_oe, per_in, pull_en, pull_up;
  logic        irq;

  int n_cmp = 0;
  int n_bad = 0;

  gpio_port #(
    .BASE    (Base),
    .PORT_IV (1'b1)
  ) dut (
    .MCLK    (mclk),
    .RSTn    (rstn),
    .MAB     (mab),
    .MDBin   (mdb_in),
    .MDBout  (mdb_out),
    .MW      (mw),
    .MR      (mr),
    .BW      (bw),
    .PAD_O   (pad_o),
    .PAD_I   (pad_i),
    .PAD_T   (pad_t),
    .PER_OUT (per_out),
    .PER_OE  (per_oe),
    .PER_IN  (per_in),
    .PULL_EN (pull_en),
    .PULL_UP (pull_up),
    .INT     (irq)
  );

  always #5 mclk = ~mclk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h", tag, obs, exp);
    end
  endtask

  // Combinational readback; caller is already in the low phase of the clock.
  task automatic peek(input logic [4:0] off, output logic [15:0] d);
    mab = Base + {11'd0, off};
    #1;
    d = mdb_out;
  endtask

  task automatic wr_reg(input logic [15:0] addr, input logic [15:0] d, input logic is_bw);
    @(negedge mclk);
    mab = addr; mdb_in = d; bw = is_bw; mw = 1'b1;
    @(negedge mclk);
    mw = 1'b0; bw = 1'b0;
  endtask

  // Strobed IV read: samples the vector, then lets the clearing edge happen.
  task automatic rd_iv(output logic [15:0] d);
    @(negedge mclk);
    mab = Base + 16'h000E; mr = 1'b1;
    #1;
    d = mdb_out;
    @(negedge mclk);
    mr = 1'b0;
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge mclk);
  endtask

  logic [15:0] d;

  initial begin
    rstn = 1'b0; mab = '0; mdb_in = '0; mw = 1'b0; mr = 1'b0; bw = 1'b0;
    pad_o = 8'h00; per_out = 8'h00; per_oe = 8'h00;
    #1;
    check("rst_pad_t", {8'h00, pad_t}, 16'h00FF);
    check("rst_pad_i", {8'h00, pad_i}, 16'h0000);
    check("rst_int", {15'd0, irq}, 16'h0000);
    check("rst_pull", {pull_en, pull_up}, 16'h0000);
    settle(2);
    rstn = 1'b1;

    wr_reg(Base + 16'h0004, 16'h000F, 1'b0);
    wr_reg(Base + 16'h0002, 16'h0005, 1'b0);
    check("dir_pad_t", {8'h00, pad_t}, 16'h00F0);
    check("out_pad_i", {8'h00, pad_i}, 16'h0005);
    peek(5'h04, d); check("dir_rb", d, 16'h000F);

    // Input synchronizer and rising-edge flags.
    wr_reg(Base + 16'h001A, 16'h0001, 1'b0);
    @(negedge mclk); pad_o = 8'h81;
    @(posedge mclk); @(negedge mclk);
    peek(5'h00, d); check("in_edge1", d, 16'h0000);
    @(posedge mclk); @(negedge mclk);
    peek(5'h00, d); check("in_edge2", d, 16'h0081);
    check("per_in", {8'h00, per_in}, 16'h0081);
    peek(5'h1C, d); check("ifg_edge2", d, 16'h0000);
    @(posedge mclk); @(negedge mclk);
    peek(5'h1C, d); check("ifg_edge3", d, 16'h0081);
    check("int_set", {15'd0, irq}, 16'h0001);
    rd_iv(d); check("iv_first", d, 16'h0002);
    check("int_clr", {15'd0, irq}, 16'h0000);
    rd_iv(d); check("iv_second", d, 16'h0000);
    peek(5'h1C, d); check("ifg_after_iv", d, 16'h0080);

    // Falling-edge select; rising edges under IES=1 must not flag.
    wr_reg(Base + 16'h0018, 16'h00FF, 1'b0);
    @(negedge mclk); pad_o = 8'hFF;
    settle(4);
    wr_reg(Base + 16'h001C, 16'h0000, 1'b0);
    @(negedge mclk); pad_o = 8'hFE;
    settle(4);
    peek(5'h1C, d); check("ifg_fall", d, 16'h0001);
    wr_reg(Base + 16'h0018, 16'h0000, 1'b0);
    settle(2);
    peek(5'h1C, d); check("ifg_ies_wr", d, 16'h0001);

    // Hardware set on bit 3 collides with a software write of zero.
    @(negedge mclk); pad_o = 8'hF6;
    settle(4);
    wr_reg(Base + 16'h001C, 16'h0040, 1'b0);
    @(negedge mclk); pad_o = 8'hFE;
    @(posedge mclk); @(posedge mclk);
    wr_reg(Base + 16'h001C, 16'h0000, 1'b0);
    peek(5'h1C, d); check("coll_wr", d, 16'h0008);

    // Same collision against the IV-read clear.
    wr_reg(Base + 16'h001A, 16'h0008, 1'b0);
    @(negedge mclk); pad_o = 8'hF6;
    settle(4);
    @(negedge mclk); pad_o = 8'hFE;
    @(posedge mclk); @(posedge mclk);
    rd_iv(d); check("coll_iv_val", d, 16'h0008);
    peek(5'h1C, d); check("coll_iv_ifg", d, 16'h0008);
    check("coll_int", {15'd0, irq}, 16'h0001);

    // Peripheral mux on bit 4 only.
    wr_reg(Base + 16'h0004, 16'h0000, 1'b0);
    per_oe = 8'h10; per_out = 8'h10;
    wr_reg(Base + 16'h000A, 16'h0010, 1'b0);
    check("mux_pad_t", {8'h00, pad_t}, 16'h00EF);
    check("mux_pad_i", {8'h00, pad_i}, 16'h0015);

    // Bus decode.
    wr_reg(Base + 16'h0003, 16'h00AB, 1'b1);
    peek(5'h02, d); check("bw_odd_ign", d, 16'h0005);
    peek(5'h03, d); check("odd_read", d, 16'h0000);
    wr_reg(Base + 16'h0002, 16'h12FF, 1'b0);
    peek(5'h02, d); check("word_wr", d, 16'h00FF);
    peek(5'h08, d); check("unmapped", d, 16'h0000);
    wr_reg(Base + 16'h0000, 16'h0055, 1'b0);
    peek(5'h00, d); check("in_ro", d, 16'h00FE);
    wr_reg(Base + 16'h0006, 16'h000C, 1'b0);
    check("pull_en", {8'h00, pull_en}, 16'h000C);
    check("pull_up", {8'h00, pull_up}, 16'h000C);
    mab = 16'h0300; #1;
    check("not_addr", mdb_out, 16'h0000);

    // Asynchronous reset in the middle of traffic.
    wr_reg(Base + 16'h0004, 16'h00F0, 1'b0);
    @(negedge mclk); #2;
    rstn = 1'b0;
    #1;
    check("mid_pad_t", {8'h00, pad_t}, 16'h00FF);
    check("mid_int", {15'd0, irq}, 16'h0000);
    peek(5'h02, d); check("mid_out", d, 16'h0000);
    peek(5'h1C, d); check("mid_ifg", d, 16'h0000);
    peek(5'h1A, d); check("mid_ie", d, 16'h0000);
    peek(5'h00, d); check("mid_in", d, 16'h0000);
    settle(2);
    rstn = 1'b1;
    settle(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no finish, expected finish before 20000");
    $fatal(1);
  end

endmodule
